// File: rtl/ice_fm_fsk_ctrl_if.sv
// Byte handshake and FM transmitter drive bundle for the FSK frame sequencer.
interface ice_fm_fsk_ctrl_if #(
  parameter int unsigned INC_W = 24
) ();
  logic [7:0]       data;
  logic             valid;
  logic             ready;
  logic [INC_W-1:0] inc;
  logic             key;
  logic             busy;

  modport master (output data, valid, input ready, inc, key, busy);
  modport slave  (input data, valid, output ready, inc, key, busy);
endinterface

// File: rtl/ice_fm_fsk_ctrl.sv
// Binary-FSK frame sequencer: lead-in, start/8 data (LSB first)/stop bits and hang
// time, driving the FM transmitter's carrier key and phase-increment word.
module ice_fm_fsk_ctrl #(
  parameter int unsigned      BIT_CYCLES = 1250,
  parameter int unsigned      INC_W      = 24,
  parameter logic [INC_W-1:0] MARK_INC   = INC_W'(13981),
  parameter logic [INC_W-1:0] SPACE_INC  = INC_W'(12583),
  parameter int unsigned      LEAD_BITS  = 2,
  parameter int unsigned      HANG_BITS  = 4
) (
  input logic              i_clk,
  input logic              i_nrst,
  ice_fm_fsk_ctrl_if.slave bus
);

  localparam int unsigned BC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BT_MAX = (LEAD_BITS > HANG_BITS) ? LEAD_BITS : HANG_BITS;
  localparam int unsigned BT_W   = (BT_MAX > 1) ? $clog2(BT_MAX) : 1;

  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BIT_CYCLES - 1);
  localparam logic [BT_W-1:0] LEAD_LAST = BT_W'((LEAD_BITS > 0) ? LEAD_BITS - 1 : 0);
  localparam logic [BT_W-1:0] HANG_LAST = BT_W'((HANG_BITS > 0) ? HANG_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    HANG  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [BT_W-1:0]  bt_cnt, bt_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             key_nxt, busy_nxt, ready_nxt;
  logic [INC_W-1:0] inc_nxt;
  logic             xfer_c;
  logic             eob_c;

  assign xfer_c = bus.valid & bus.ready;
  assign eob_c  = (bit_cnt == BC_LAST);

  // State, counters, shift register and registered outputs
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bt_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      bus.key   <= 1'b0;
      bus.inc   <= MARK_INC;
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bt_cnt    <= bt_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      bus.key   <= key_nxt;
      bus.inc   <= inc_nxt;
      bus.ready <= ready_nxt;
      bus.busy  <= busy_nxt;
    end
  end

  // Next state, counters and Moore outputs derived from the next state
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = eob_c ? '0 : bit_cnt + BC_W'(1);
    bt_cnt_nxt  = bt_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    key_nxt     = 1'b0;
    busy_nxt    = 1'b0;
    ready_nxt   = 1'b0;
    inc_nxt     = MARK_INC;

    unique case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        if (xfer_c) begin
          shreg_nxt = bus.data;
          state_nxt = (LEAD_BITS == 0) ? START : LEAD;
        end
      end
      LEAD: begin
        if (eob_c) begin
          if (bt_cnt == LEAD_LAST) state_nxt = START;
          else                     bt_cnt_nxt = bt_cnt + BT_W'(1);
        end
      end
      START: begin
        if (eob_c) state_nxt = DATA;
      end
      DATA: begin
        if (eob_c) begin
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // A byte accepted in the last stop cycle chains straight into the next start bit
        if (eob_c) begin
          if (xfer_c) begin
            shreg_nxt = bus.data;
            state_nxt = START;
          end else begin
            state_nxt = (HANG_BITS == 0) ? IDLE : HANG;
          end
        end
      end
      HANG: begin
        if (xfer_c) begin
          shreg_nxt = bus.data;
          state_nxt = START;
        end else if (eob_c) begin
          if (bt_cnt == HANG_LAST) state_nxt = IDLE;
          else                     bt_cnt_nxt = bt_cnt + BT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      bit_cnt_nxt = '0;
      bt_cnt_nxt  = '0;
      bit_idx_nxt = '0;
    end

    key_nxt   = (state_nxt != IDLE);
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE) || (state_nxt == HANG) ||
                ((state_nxt == STOP) && (bit_cnt_nxt == BC_LAST));

    if (state_nxt == START)     inc_nxt = SPACE_INC;
    else if (state_nxt == DATA) inc_nxt = shreg_nxt[0] ? MARK_INC : SPACE_INC;
  end

endmodule

// File: tb/tb_ice_fm_fsk_ctrl.sv
// Bench for ice_fm_fsk_ctrl: per-cycle timeline model for two parameter sets plus
// hand-computed run lengths, bit patterns and handshake timing.
module tb_ice_fm_fsk_ctrl;

  localparam logic [23:0] MARK  = 24'd13981;
  localparam logic [23:0] SPACE = 24'd12583;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ice_fm_fsk_ctrl_if #(.INC_W(24)) bus_a ();
  ice_fm_fsk_ctrl_if #(.INC_W(24)) bus_b ();

  ice_fm_fsk_ctrl #(
    .BIT_CYCLES(4), .INC_W(24), .MARK_INC(MARK), .SPACE_INC(SPACE),
    .LEAD_BITS(2), .HANG_BITS(4)
  ) dut_a (
    .i_clk (clk),
    .i_nrst(rst_a),
    .bus   (bus_a)
  );

  ice_fm_fsk_ctrl #(
    .BIT_CYCLES(1), .INC_W(24), .MARK_INC(MARK), .SPACE_INC(SPACE),
    .LEAD_BITS(0), .HANG_BITS(0)
  ) dut_b (
    .i_clk (clk),
    .i_nrst(rst_b),
    .bus   (bus_b)
  );

  // One entry per keyed cycle still to be shown: increment word and whether a byte is accepted then
  typedef struct packed {
    logic [23:0] inc;
    logic        rdy;
  } sym_t;
  typedef sym_t        sym_q_t[$];
  typedef logic [23:0] inc_q_t[$];

  sym_q_t qa, qb;

  function automatic sym_t mk(input logic [23:0] inc, input logic rdy);
    sym_t s;
    s.inc = inc;
    s.rdy = rdy;
    return s;
  endfunction

  function automatic sym_q_t frame(input logic [7:0] b, input int lead, input int bc, input int hang);
    sym_q_t q;
    for (int i = 0; i < lead * bc; i++) q.push_back(mk(MARK, 1'b0));
    for (int i = 0; i < bc; i++)        q.push_back(mk(SPACE, 1'b0));
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < bc; i++)      q.push_back(mk(b[k] ? MARK : SPACE, 1'b0));
    for (int i = 0; i < bc; i++)        q.push_back(mk(MARK, i == bc - 1));
    for (int i = 0; i < hang * bc; i++) q.push_back(mk(MARK, 1'b1));
    return q;
  endfunction

  // An accepted byte replaces whatever stop/hang remains; lead-in only when starting from idle
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) qa.delete();
    else if (bus_a.valid && (qa.size() == 0 || qa[0].rdy)) qa = frame(bus_a.data, (qa.size() == 0) ? 2 : 0, 4, 4);
    else if (qa.size() != 0) void'(qa.pop_front());
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) qb.delete();
    else if (bus_b.valid && (qb.size() == 0 || qb[0].rdy)) qb = frame(bus_b.data, 0, 1, 0);
    else if (qb.size() != 0) void'(qb.pop_front());
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if ($time > 2) begin
      cmp("a_key",   32'(bus_a.key),   (qa.size() != 0) ? 32'd1 : 32'd0);
      cmp("a_busy",  32'(bus_a.busy),  (qa.size() != 0) ? 32'd1 : 32'd0);
      cmp("a_inc",   32'(bus_a.inc),   (qa.size() != 0) ? 32'(qa[0].inc) : 32'(MARK));
      cmp("a_ready", 32'(bus_a.ready), (qa.size() != 0) ? 32'(qa[0].rdy) : 32'd1);
      cmp("b_key",   32'(bus_b.key),   (qb.size() != 0) ? 32'd1 : 32'd0);
      cmp("b_busy",  32'(bus_b.busy),  (qb.size() != 0) ? 32'd1 : 32'd0);
      cmp("b_inc",   32'(bus_b.inc),   (qb.size() != 0) ? 32'(qb[0].inc) : 32'(MARK));
      cmp("b_ready", 32'(bus_b.ready), (qb.size() != 0) ? 32'(qb[0].rdy) : 32'd1);
    end
  end

  // Length of each continuous key-high run, and the increment seen in every keyed cycle
  int     run_a = 0, last_a = 0, run_b = 0, last_b = 0;
  inc_q_t cap_a, cap_b;

  always @(negedge clk) begin
    if (bus_a.key === 1'b1) begin
      run_a++;
      cap_a.push_back(bus_a.inc);
    end else if (run_a != 0) begin
      last_a = run_a;
      run_a  = 0;
    end
    if (bus_b.key === 1'b1) begin
      run_b++;
      cap_b.push_back(bus_b.inc);
    end else if (run_b != 0) begin
      last_b = run_b;
      run_b  = 0;
    end
  end

  task automatic send(input bit on_b, input logic [7:0] b);
    logic r;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    if (on_b) begin bus_b.data = b; bus_b.valid = 1'b1; end
    else      begin bus_a.data = b; bus_a.valid = 1'b1; end
    for (int n = 0; n < 300 && !done; n++) begin
      if (n != 0) @(negedge clk);
      r = on_b ? bus_b.ready : bus_a.ready;
      @(posedge clk);
      done = (r === 1'b1);
    end
    cmp("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
  endtask

  task automatic wait_idle(input bit on_b);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = ((on_b ? bus_b.busy : bus_a.busy) === 1'b0);
    end
    cmp("wait_idle", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // bits: expected data bits in transmission order, checked one sample per bit time
  task automatic chk_bits(input string name, input inc_q_t cap, input int base, input int stride,
                          input string bits);
    logic [23:0] e;
    for (int k = 0; k < bits.len(); k++) begin
      e = (bits[k] == "1") ? MARK : SPACE;
      cmp(name, 32'(cap[base + stride * k]), 32'(e));
    end
  endtask

  time t0;

  initial begin
    bus_a.valid = 1'b0; bus_a.data = '0;
    bus_b.valid = 1'b0; bus_b.data = '0;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    cmp("rst_key",   32'(bus_a.key),   32'd0);
    cmp("rst_inc",   32'(bus_a.inc),   32'(MARK));
    cmp("rst_ready", 32'(bus_a.ready), 32'd1);
    cmp("rst_busy",  32'(bus_a.busy),  32'd0);
    #2 rst_a = 1'b1; rst_b = 1'b1;

    // Single byte 0xA5: 8 lead, 4 start, 32 data, 4 stop, 16 hang
    cap_a.delete();
    send(1'b0, 8'hA5);
    drop_valid();
    wait_idle(1'b0);
    cmp("a5_key_cycles", 32'(last_a), 32'd64);
    cmp("a5_lead",  32'(cap_a[5]),  32'(MARK));
    cmp("a5_start", 32'(cap_a[10]), 32'(SPACE));
    chk_bits("a5_bits", cap_a, 13, 4, "10100101");
    cmp("a5_stop",  32'(cap_a[46]), 32'(MARK));
    cmp("a5_hang",  32'(cap_a[63]), 32'(MARK));

    // Back-to-back 0x00 then 0xFF with valid held: one unbroken keyed run
    cap_a.delete();
    send(1'b0, 8'h00);
    t0 = $time;
    send(1'b0, 8'hFF);
    cmp("b2b_accept_cycle", 32'(($time - t0) / 10), 32'd48);
    drop_valid();
    wait_idle(1'b0);
    cmp("b2b_key_cycles", 32'(last_a), 32'd104);
    chk_bits("b2b_00", cap_a, 13, 4, "00000000");
    cmp("b2b_start2", 32'(cap_a[49]), 32'(SPACE));
    chk_bits("b2b_ff", cap_a, 53, 4, "11111111");

    // Transfer 6 cycles into hang, then another in the final hang cycle
    send(1'b0, 8'h81);
    drop_valid();
    repeat (53) @(posedge clk);
    send(1'b0, 8'h0F);
    drop_valid();
    repeat (55) @(posedge clk);
    send(1'b0, 8'h33);
    drop_valid();
    wait_idle(1'b0);
    cmp("hang_key_cycles", 32'(last_a), 32'd166);

    // Valid with 0x3C raised during data is held off until the last stop cycle
    cap_a.delete();
    send(1'b0, 8'h5A);
    t0 = $time;
    drop_valid();
    repeat (20) @(posedge clk);
    send(1'b0, 8'h3C);
    cmp("blocked_accept_cycle", 32'(($time - t0) / 10), 32'd48);
    drop_valid();
    wait_idle(1'b0);
    cmp("blocked_key_cycles", 32'(last_a), 32'd104);
    chk_bits("blocked_5a", cap_a, 13, 4, "01011010");
    chk_bits("blocked_3c", cap_a, 53, 4, "00111100");

    // Reset during data bit 3 takes effect without a clock edge
    send(1'b0, 8'h96);
    drop_valid();
    repeat (25) @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    cmp("mid_rst_key",   32'(bus_a.key),   32'd0);
    cmp("mid_rst_inc",   32'(bus_a.inc),   32'(MARK));
    cmp("mid_rst_ready", 32'(bus_a.ready), 32'd1);
    cmp("mid_rst_busy",  32'(bus_a.busy),  32'd0);
    repeat (2) @(negedge clk);
    cmp("mid_rst_run", 32'(last_a), 32'd25);
    #2 rst_a = 1'b1;
    cap_a.delete();
    send(1'b0, 8'h11);
    drop_valid();
    wait_idle(1'b0);
    cmp("post_rst_key_cycles", 32'(last_a), 32'd64);
    cmp("post_rst_lead", 32'(cap_a[6]), 32'(MARK));

    // No lead, no hang, one cycle per bit
    cap_b.delete();
    send(1'b1, 8'hC3);
    drop_valid();
    wait_idle(1'b1);
    cmp("edge_key_cycles", 32'(last_b), 32'd10);
    cmp("edge_start", 32'(cap_b[0]), 32'(SPACE));
    chk_bits("edge_bits", cap_b, 1, 1, "11000011");
    cmp("edge_stop", 32'(cap_b[9]), 32'(MARK));

    cap_b.delete();
    send(1'b1, 8'h01);
    send(1'b1, 8'h80);
    drop_valid();
    wait_idle(1'b1);
    cmp("edge_b2b_key_cycles", 32'(last_b), 32'd20);
    chk_bits("edge_b2b_80", cap_b, 11, 1, "00000001");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
